// File: rtl/input_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer_if
// Description : Raw input, control and debounced outputs of input_debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_debouncer_if #(
    parameter int GLITCH_W = 8
);
    logic                noisy_in;
    logic                enable;
    logic                glitch_clr;
    logic                clean_out;
    logic                changed;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output noisy_in, enable, glitch_clr,
        input  clean_out, changed, glitch_cnt
    );

    modport slave (
        input  noisy_in, enable, glitch_clr,
        output clean_out, changed, glitch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Synchronizes and debounces a raw input; counts rejected glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int GLITCH_W      = 8
) (
    input  wire              clk,
    input  wire              rst,
    input_debouncer_if.slave bus
);
    localparam int                   c_CNT_W      = $clog2(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST   = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0]  c_GLITCH_MAX = {GLITCH_W{1'b1}};

    typedef enum logic [1:0] {
        STABLE_LOW   = 2'd0,
        CONFIRM_HIGH = 2'd1,
        STABLE_HIGH  = 2'd2,
        CONFIRM_LOW  = 2'd3
    } state_t;

    logic                r_sync1;
    logic                r_sync2;
    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_clean_out;
    logic                r_changed;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_clean_nxt;
    logic                w_changed_nxt;
    logic                w_glitch_inc;

    // Two-flop synchronizer: noisy_in is unrelated to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.noisy_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= STABLE_LOW;
            r_cnt       <= '0;
            r_clean_out <= 1'b0;
            r_changed   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_clean_out <= w_clean_nxt;
            r_changed   <= w_changed_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_clean_nxt   = r_clean_out;
        w_changed_nxt = 1'b0;
        w_glitch_inc  = 1'b0;
        case (r_state)
            STABLE_LOW: begin
                if (bus.enable && r_sync2) begin
                    w_state_nxt = CONFIRM_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            CONFIRM_HIGH: begin
                if (!bus.enable) begin
                    w_state_nxt = STABLE_LOW;
                end else if (r_sync2) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt   = STABLE_HIGH;
                        w_clean_nxt   = 1'b1;
                        w_changed_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end else begin
                    w_state_nxt  = STABLE_LOW;
                    w_glitch_inc = 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (bus.enable && !r_sync2) begin
                    w_state_nxt = CONFIRM_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            CONFIRM_LOW: begin
                if (!bus.enable) begin
                    w_state_nxt = STABLE_HIGH;
                end else if (!r_sync2) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt   = STABLE_LOW;
                        w_clean_nxt   = 1'b0;
                        w_changed_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end else begin
                    w_state_nxt  = STABLE_HIGH;
                    w_glitch_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = STABLE_LOW;
            end
        endcase
    end

    // Clear wins over a coincident increment; the count saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (rst || bus.glitch_clr) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch_inc && (r_glitch_cnt != c_GLITCH_MAX)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign bus.clean_out  = r_clean_out;
    assign bus.changed    = r_changed;
    assign bus.glitch_cnt = r_glitch_cnt;
endmodule
`default_nettype wire

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, number of consecutive synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter GLITCH_W, default 8, width of the glitch counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port noisy_in  input  1  asynchronous raw input (button/switch), unrelated to clk.
REQ-006 SHALL have port enable  input  1  when high, level changes may be accepted.
REQ-007 SHALL have port glitch_clr  input  1  synchronous clear of glitch_cnt.
REQ-008 SHALL have port clean_out  output  1  registered debounced level; this feeds the downstream edge-pulse stage.
REQ-009 SHALL have port changed  output  1  registered one-cycle pulse when clean_out toggles.
REQ-010 SHALL have port glitch_cnt  output  GLITCH_W  registered count of rejected candidate transitions.

Function
REQ-011 SHALL pass noisy_in through a two-flop synchronizer (sync1 -> sync2); only sync2 is used by the remaining logic.
REQ-012 SHALL implement FSM states STABLE_LOW, CONFIRM_HIGH, STABLE_HIGH, CONFIRM_LOW.
REQ-013 STABLE_LOW: if enable=1 and sync2=1 -> CONFIRM_HIGH with cnt=0; otherwise stay.
REQ-014 CONFIRM_HIGH, sync2=1, enable=1: if cnt==STABLE_CYCLES-1 -> STABLE_HIGH, clean_out<=1, changed<=1; else cnt<=cnt+1.
REQ-015 CONFIRM_HIGH, sync2=0, enable=1: -> STABLE_LOW, glitch_cnt increments; clean_out unchanged.
REQ-016 STABLE_HIGH and CONFIRM_LOW SHALL mirror REQ-013..015 with sync2=0 as the candidate level and clean_out<=0 on acceptance.
REQ-017 In any CONFIRM state with enable=0: return to the matching STABLE state; no glitch_cnt increment; clean_out unchanged.
REQ-018 Net latency: for a noisy_in change held stable, clean_out SHALL update at the (STABLE_CYCLES+3)th rising edge, counting the first edge that samples the new value as edge 1.
REQ-019 changed SHALL be high for exactly the one cycle after clean_out updates; low at all other times.
REQ-020 glitch_cnt SHALL saturate at 2^GLITCH_W-1; no wrap.
REQ-021 glitch_clr=1 SHALL set glitch_cnt to 0 at the next edge and take priority over a simultaneous increment.
REQ-022 cnt width SHALL be ceil(log2(STABLE_CYCLES)); cnt SHALL never exceed STABLE_CYCLES-1.
REQ-023 A pulse on noisy_in shorter than STABLE_CYCLES synchronized cycles SHALL never change clean_out.

Reset
REQ-024 rst=1 at a rising edge SHALL set sync1, sync2, cnt, clean_out, changed and glitch_cnt to 0, and the state to STABLE_LOW, overriding all other inputs.
REQ-025 Reset asserted during a CONFIRM state SHALL abandon the candidate without a glitch_cnt increment.
REQ-026 If noisy_in is high when reset is released, clean_out SHALL rise after the REQ-018 latency with a changed pulse.

Verification (STABLE_CYCLES=4, GLITCH_W=8)
REQ-027 enable=1, noisy_in 0->1 held -> clean_out=1 at edge 7, changed=1 for that one cycle only, glitch_cnt=0.
REQ-028 noisy_in high for 2 cycles, then low -> clean_out stays 0, changed never asserts, glitch_cnt=1.
REQ-029 300 short glitches -> glitch_cnt=255 and holds; glitch_clr=1 coincident with a glitch -> glitch_cnt=0.
REQ-030 rst=1 two edges into CONFIRM_HIGH -> all outputs 0 next edge; glitch_cnt stays 0; after release with noisy_in held high, clean_out=1 at edge 7 after release.
REQ-031 enable=0 mid-CONFIRM_HIGH, noisy_in held high -> clean_out stays 0, glitch_cnt unchanged; enable=1 again -> clean_out=1 after STABLE_CYCLES+1 further edges.
REQ-032 clean_out=1, then noisy_in 1->0 held -> clean_out=0 at edge 7, one changed pulse; a 1-cycle dip while high -> no change, glitch_cnt+1.
